// File: rtl/mips_pkg.sv
// Shared definitions for the EX/MEM pipeline stage: ALU opcodes, status bit
// positions, trap cause encodings and the trap FSM state type.
package mips_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_DIV = 4'b1001;

    localparam int ST_ZERO  = 7;
    localparam int ST_OVF   = 6;
    localparam int ST_CARRY = 5;
    localparam int ST_NEG   = 4;
    localparam int ST_ODD   = 3;
    localparam int ST_DIVZ  = 2;

    // Bits 1:0 of the status byte are reserved and never accumulate.
    localparam logic [7:0] STICKY_MASK = 8'hFC;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_OVF  = 2'b01;
    localparam logic [1:0] CAUSE_DIVZ = 2'b10;
    localparam logic [1:0] CAUSE_BOTH = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        TRAP_PEND = 2'b01,
        TRAP_ACK  = 2'b10
    } trap_state_e;

    function automatic logic is_ovf_op(input logic [3:0] ctrl);
        return (ctrl == ALU_ADD) || (ctrl == ALU_SUB) || (ctrl == ALU_MUL);
    endfunction

endpackage

// File: rtl/ex_mem_trap_fsm.sv
// Trap handshake controller: raises trap_req after a trapping accept, waits for
// trap_ack, spends one recovery cycle in TRAP_ACK, then returns to IDLE.
module ex_mem_trap_fsm
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trap_fire,
    input  logic [1:0]  cause_in,
    input  logic        trap_ack,
    output trap_state_e state,
    output logic        trap_req,
    output logic [1:0]  trap_cause
);

    trap_state_e r_state;
    trap_state_e w_next_state;
    logic [1:0]  r_cause;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cause <= CAUSE_NONE;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && trap_fire) begin
                r_cause <= cause_in;
            end else if (w_next_state == IDLE) begin
                r_cause <= CAUSE_NONE;
            end
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      if (trap_fire) w_next_state = TRAP_PEND;
            TRAP_PEND: if (trap_ack)  w_next_state = TRAP_ACK;
            TRAP_ACK:  w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    // Decoded from the state register so reset drops the request immediately.
    assign trap_req   = (r_state == TRAP_PEND);
    assign trap_cause = r_cause;
    assign state      = r_state;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, overflow and
// divide-by-zero trap detection. Optional sticky status: EX_MEM_STATUS_STICKY_EN.
module ex_mem_stage
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [7:0]            alu_status,
    input  logic [3:0]            alu_ctrl,
    input  logic [DATA_W-1:0]     store_data,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  reg_write,
    input  logic                  trap_en,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_alu_result,
    output logic [DATA_W-1:0]     out_store_data,
    output logic [REG_ADDR_W-1:0] out_rd_addr,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  out_reg_write,
    output logic [7:0]            status_q,
    output logic                  trap_req,
    output logic [1:0]            trap_cause,
    input  logic                  trap_ack,
    output logic [7:0]            sticky_status,
    input  logic                  sticky_clr
);

    trap_state_e           w_state;
    logic                  w_accept;
    logic                  w_ovf_trap;
    logic                  w_dz_trap;
    logic                  w_trap_fire;
    logic [1:0]            w_trap_cause;

    logic                  r_out_valid;
    logic [DATA_W-1:0]     r_alu_result;
    logic [DATA_W-1:0]     r_store_data;
    logic [REG_ADDR_W-1:0] r_rd_addr;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic                  r_reg_write;
    logic [7:0]            r_status_q;

    // rst_n is folded in so the stage never advertises space while held in reset.
    assign in_ready = rst_n && (!r_out_valid || out_ready) && (w_state == IDLE) && !flush;
    assign w_accept = in_valid && in_ready;

    assign w_ovf_trap   = alu_status[ST_OVF] && trap_en && is_ovf_op(alu_ctrl);
    assign w_dz_trap    = alu_status[ST_DIVZ] && (alu_ctrl == ALU_DIV);
    assign w_trap_fire  = w_accept && (w_ovf_trap || w_dz_trap);
    assign w_trap_cause = (w_ovf_trap ? CAUSE_OVF : CAUSE_NONE) | (w_dz_trap ? CAUSE_DIVZ : CAUSE_NONE);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // NOTE: the payload is reset because its outputs must read zero during
    // reset; these are plain flops, not a memory array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_result <= '0;
            r_store_data <= '0;
            r_rd_addr    <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_reg_write  <= 1'b0;
            r_status_q   <= '0;
        end else if (w_accept) begin
            r_alu_result <= alu_result;
            r_store_data <= store_data;
            r_rd_addr    <= rd_addr;
            // A trapping instruction still flows down but must not commit.
            r_mem_read   <= mem_read  && !w_trap_fire;
            r_mem_write  <= mem_write && !w_trap_fire;
            r_reg_write  <= reg_write && !w_trap_fire;
            r_status_q   <= alu_status;
        end
    end

    assign out_valid      = r_out_valid;
    assign out_alu_result = r_alu_result;
    assign out_store_data = r_store_data;
    assign out_rd_addr    = r_rd_addr;
    assign out_mem_read   = r_mem_read;
    assign out_mem_write  = r_mem_write;
    assign out_reg_write  = r_reg_write;
    assign status_q       = r_status_q;

`ifdef EX_MEM_STATUS_STICKY_EN
    logic [7:0] r_sticky;

    // Clear takes priority over the old value but never over the new accept's flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= ({8{!sticky_clr}} & r_sticky)
                      | ({8{w_accept}} & alu_status & STICKY_MASK);
        end
    end

    assign sticky_status = r_sticky;
`else
    logic w_unused_sticky_clr;

    assign w_unused_sticky_clr = sticky_clr;
    assign sticky_status       = '0;
`endif

    ex_mem_trap_fsm u_trap_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .trap_fire  (w_trap_fire),
        .cause_in   (w_trap_cause),
        .trap_ack   (trap_ack),
        .state      (w_state),
        .trap_req   (trap_req),
        .trap_cause (trap_cause)
    );

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus a randomized
// run against a cycle-level behavioural model.
module tb_ex_mem_stage;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     alu_result;
    logic [7:0]            alu_status;
    logic [3:0]            alu_ctrl;
    logic [DATA_W-1:0]     store_data;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  mem_read, mem_write, reg_write;
    logic                  trap_en, flush;
    logic                  out_valid, out_ready;
    logic [DATA_W-1:0]     out_alu_result, out_store_data;
    logic [REG_ADDR_W-1:0] out_rd_addr;
    logic                  out_mem_read, out_mem_write, out_reg_write;
    logic [7:0]            status_q;
    logic                  trap_req, trap_ack;
    logic [1:0]            trap_cause;
    logic [7:0]            sticky_status;
    logic                  sticky_clr;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [DATA_W-1:0]     alu;
        logic [DATA_W-1:0]     sd;
        logic [REG_ADDR_W-1:0] rd;
        logic                  mr;
        logic                  mw;
        logic                  rw;
    } entry_t;

    always #5 clk = ~clk;

    ex_mem_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_status(alu_status), .alu_ctrl(alu_ctrl),
        .store_data(store_data), .rd_addr(rd_addr),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .trap_en(trap_en), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_result(out_alu_result), .out_store_data(out_store_data),
        .out_rd_addr(out_rd_addr), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_reg_write(out_reg_write),
        .status_q(status_q), .trap_req(trap_req), .trap_cause(trap_cause),
        .trap_ack(trap_ack), .sticky_status(sticky_status), .sticky_clr(sticky_clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        in_valid = 0; alu_result = '0; alu_status = '0; alu_ctrl = '0;
        store_data = '0; rd_addr = '0; mem_read = 0; mem_write = 0; reg_write = 0;
        trap_en = 0; flush = 0; out_ready = 0; trap_ack = 0; sticky_clr = 0;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        drive_idle();
        step();
        step();
        rst_n = 1;
    endtask

    task automatic ack_trap();
        trap_ack = 1;
        step();
        trap_ack = 0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 0;
        drive_idle();
        step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0h exp=0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%0h exp=0", in_ready); else n_pass++;
        n_checks++; if (out_alu_result !== '0) $display("FAIL reset_alu got=%0h exp=0", out_alu_result); else n_pass++;
        n_checks++; if (out_store_data !== '0) $display("FAIL reset_sd got=%0h exp=0", out_store_data); else n_pass++;
        n_checks++; if (out_rd_addr !== '0) $display("FAIL reset_rd got=%0h exp=0", out_rd_addr); else n_pass++;
        n_checks++; if ({out_mem_read, out_mem_write, out_reg_write} !== 3'b000)
            $display("FAIL reset_ctrl got=%0b exp=000", {out_mem_read, out_mem_write, out_reg_write}); else n_pass++;
        n_checks++; if (status_q !== 8'h00) $display("FAIL reset_status got=%0h exp=0", status_q); else n_pass++;
        n_checks++; if (sticky_status !== 8'h00) $display("FAIL reset_sticky got=%0h exp=0", sticky_status); else n_pass++;
        n_checks++; if (trap_req !== 1'b0) $display("FAIL reset_trap_req got=%0h exp=0", trap_req); else n_pass++;
        n_checks++; if (trap_cause !== 2'b00) $display("FAIL reset_cause got=%0b exp=00", trap_cause); else n_pass++;
        rst_n = 1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got=%0h exp=1", in_ready); else n_pass++;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        out_ready = 1;
        in_valid  = 1;
        reg_write = 1;
        for (int i = 0; i < 3; i++) begin
            alu_result = DATA_W'(5 + i);
            rd_addr    = REG_ADDR_W'(i + 1);
            #1;
            n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d] got=%0h exp=1", i, in_ready); else n_pass++;
            step();
            n_checks++; if (out_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got=%0h exp=1", i, out_valid); else n_pass++;
            n_checks++; if (out_alu_result !== DATA_W'(5 + i))
                $display("FAIL b2b_alu[%0d] got=%0h exp=%0h", i, out_alu_result, 5 + i); else n_pass++;
            n_checks++; if (out_rd_addr !== REG_ADDR_W'(i + 1))
                $display("FAIL b2b_rd[%0d] got=%0h exp=%0h", i, out_rd_addr, i + 1); else n_pass++;
            n_checks++; if (out_reg_write !== 1'b1) $display("FAIL b2b_rw[%0d] got=%0h exp=1", i, out_reg_write); else n_pass++;
        end
        in_valid = 0;
        step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got=%0h exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready  = 0;
        in_valid   = 1;
        alu_result = 32'h0000_1234;
        store_data = 32'hCAFE_0001;
        step();
        alu_result = 32'h0000_ABCD;
        store_data = 32'hCAFE_0002;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got=%0h exp=0", i, in_ready); else n_pass++;
            n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid[%0d] got=%0h exp=1", i, out_valid); else n_pass++;
            n_checks++; if (out_alu_result !== 32'h0000_1234)
                $display("FAIL bp_hold_alu[%0d] got=%0h exp=1234", i, out_alu_result); else n_pass++;
            n_checks++; if (out_store_data !== 32'hCAFE_0001)
                $display("FAIL bp_hold_sd[%0d] got=%0h exp=cafe0001", i, out_store_data); else n_pass++;
            step();
        end
        out_ready = 1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got=%0h exp=1", in_ready); else n_pass++;
        step();
        n_checks++; if (out_alu_result !== 32'h0000_ABCD) $display("FAIL bp_new_alu got=%0h exp=abcd", out_alu_result); else n_pass++;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_new_valid got=%0h exp=1", out_valid); else n_pass++;
        in_valid = 0;
        step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_drain got=%0h exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_overflow_trap();
        apply_reset();
        out_ready = 1;
        in_valid  = 1;
        alu_ctrl  = 4'b0010;
        alu_status = 8'h50;
        trap_en   = 1;
        reg_write = 1;
        mem_write = 1;
        mem_read  = 1;
        step();
        in_valid = 0;
        #1;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL ovf_valid got=%0h exp=1", out_valid); else n_pass++;
        n_checks++; if ({out_mem_read, out_mem_write, out_reg_write} !== 3'b000)
            $display("FAIL ovf_ctrl_killed got=%0b exp=000", {out_mem_read, out_mem_write, out_reg_write}); else n_pass++;
        n_checks++; if (trap_req !== 1'b1) $display("FAIL ovf_trap_req got=%0h exp=1", trap_req); else n_pass++;
        n_checks++; if (trap_cause !== 2'b01) $display("FAIL ovf_cause got=%0b exp=01", trap_cause); else n_pass++;
        n_checks++; if (status_q !== 8'h50) $display("FAIL ovf_status got=%0h exp=50", status_q); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL ovf_pend_ready got=%0h exp=0", in_ready); else n_pass++;
        repeat (3) step();
        n_checks++; if (trap_req !== 1'b1) $display("FAIL ovf_req_held got=%0h exp=1", trap_req); else n_pass++;
        trap_ack = 1;
        step();
        trap_ack = 0;
        #1;
        n_checks++; if (trap_req !== 1'b0) $display("FAIL ovf_req_after_ack got=%0h exp=0", trap_req); else n_pass++;
        n_checks++; if (trap_cause !== 2'b01) $display("FAIL ovf_cause_ack got=%0b exp=01", trap_cause); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL ovf_ack_ready got=%0h exp=0", in_ready); else n_pass++;
        step();
        n_checks++; if (in_ready !== 1'b1) $display("FAIL ovf_idle_ready got=%0h exp=1", in_ready); else n_pass++;
        n_checks++; if (trap_cause !== 2'b00) $display("FAIL ovf_cause_idle got=%0b exp=00", trap_cause); else n_pass++;
        // Overflow flag with traps disabled must commit normally.
        in_valid = 1;
        trap_en  = 0;
        step();
        in_valid = 0;
        n_checks++; if (trap_req !== 1'b0) $display("FAIL ovf_disabled_req got=%0h exp=0", trap_req); else n_pass++;
        n_checks++; if (out_reg_write !== 1'b1) $display("FAIL ovf_disabled_rw got=%0h exp=1", out_reg_write); else n_pass++;
        drive_idle();
    endtask

    task automatic test_divzero_trap();
        apply_reset();
        out_ready  = 1;
        in_valid   = 1;
        alu_ctrl   = 4'b1001;
        alu_status = 8'h04;
        trap_en    = 0;
        reg_write  = 1;
        step();
        in_valid = 0;
        n_checks++; if (trap_req !== 1'b1) $display("FAIL dz_req got=%0h exp=1", trap_req); else n_pass++;
        n_checks++; if (trap_cause !== 2'b10) $display("FAIL dz_cause got=%0b exp=10", trap_cause); else n_pass++;
        n_checks++; if (out_reg_write !== 1'b0) $display("FAIL dz_rw got=%0h exp=0", out_reg_write); else n_pass++;
        ack_trap();
        in_valid   = 1;
        alu_status = 8'h44;
        trap_en    = 1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL dz_ready_again got=%0h exp=1", in_ready); else n_pass++;
        step();
        in_valid = 0;
        n_checks++; if (trap_cause !== 2'b10) $display("FAIL dz_ovf_ignored got=%0b exp=10", trap_cause); else n_pass++;
        ack_trap();
        drive_idle();
    endtask

    task automatic test_flush();
        apply_reset();
        in_valid   = 1;
        alu_result = 32'h0BAD_F00D;
        step();
        alu_result = 32'h1111_2222;
        flush      = 1;
        out_ready  = 1;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL flush_blocks_ready got=%0h exp=0", in_ready); else n_pass++;
        step();
        flush    = 0;
        in_valid = 0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_valid got=%0h exp=0", out_valid); else n_pass++;
        n_checks++; if (out_alu_result !== 32'h0BAD_F00D)
            $display("FAIL flush_no_accept got=%0h exp=badf00d", out_alu_result); else n_pass++;
        drive_idle();
    endtask

    task automatic test_reset_mid_trap();
        apply_reset();
        out_ready  = 1;
        in_valid   = 1;
        alu_ctrl   = 4'b1001;
        alu_status = 8'h04;
        step();
        in_valid = 0;
        n_checks++; if (trap_req !== 1'b1) $display("FAIL rst_trap_setup got=%0h exp=1", trap_req); else n_pass++;
        rst_n = 0;
        #1;
        n_checks++; if (trap_req !== 1'b0) $display("FAIL rst_trap_req_async got=%0h exp=0", trap_req); else n_pass++;
        n_checks++; if (trap_cause !== 2'b00) $display("FAIL rst_trap_cause got=%0b exp=00", trap_cause); else n_pass++;
        n_checks++; if (status_q !== 8'h00) $display("FAIL rst_trap_status got=%0h exp=0", status_q); else n_pass++;
        step();
        drive_idle();
        rst_n = 1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_trap_idle_ready got=%0h exp=1", in_ready); else n_pass++;
        step();
        n_checks++; if (trap_req !== 1'b0) $display("FAIL rst_trap_stays_low got=%0h exp=0", trap_req); else n_pass++;
    endtask

    task automatic test_sticky();
        apply_reset();
        out_ready  = 1;
        in_valid   = 1;
        alu_status = 8'h80;
        step();
        alu_status = 8'h10;
        step();
        in_valid = 0;
`ifdef EX_MEM_STATUS_STICKY_EN
        n_checks++; if (sticky_status !== 8'h90) $display("FAIL sticky_accum got=%0h exp=90", sticky_status); else n_pass++;
        sticky_clr = 1;
        step();
        sticky_clr = 0;
        n_checks++; if (sticky_status !== 8'h00) $display("FAIL sticky_clear got=%0h exp=00", sticky_status); else n_pass++;
        alu_status = 8'h80;
        in_valid   = 1;
        step();
        sticky_clr = 1;
        alu_status = 8'h23;
        step();
        sticky_clr = 0;
        in_valid   = 0;
        n_checks++; if (sticky_status !== 8'h20) $display("FAIL sticky_clr_keeps_new got=%0h exp=20", sticky_status); else n_pass++;
`else
        n_checks++; if (sticky_status !== 8'h00) $display("FAIL sticky_off got=%0h exp=00", sticky_status); else n_pass++;
        sticky_clr = 1;
        in_valid   = 1;
        step();
        sticky_clr = 0;
        in_valid   = 0;
        n_checks++; if (sticky_status !== 8'h00) $display("FAIL sticky_off_clr got=%0h exp=00", sticky_status); else n_pass++;
`endif
        drive_idle();
    endtask

    task automatic test_random();
        automatic bit         m_valid   = 0;
        automatic entry_t     m_out     = '0;
        automatic logic [7:0] m_status  = '0;
        automatic logic [7:0] m_sticky  = '0;
        automatic bit         m_waiting = 0;
        automatic int         m_recover = 0;
        automatic logic [1:0] m_cause   = 2'b00;
        automatic logic [3:0] ops[4]    = '{4'b0010, 4'b0110, 4'b1000, 4'b1001};
        automatic bit         exp_ready, acc, ovf, dz, trap;

        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 4) < 3);
            flush      = ($urandom_range(0, 9) == 0);
            trap_ack   = ($urandom_range(0, 2) == 0);
            sticky_clr = ($urandom_range(0, 5) == 0);
            trap_en    = 1'($urandom_range(0, 1));
            alu_result = $urandom;
            store_data = $urandom;
            rd_addr    = REG_ADDR_W'($urandom);
            alu_ctrl   = ($urandom_range(0, 1) != 0) ? ops[$urandom_range(0, 3)] : 4'($urandom);
            alu_status = 8'($urandom);
            mem_read   = 1'($urandom);
            mem_write  = 1'($urandom);
            reg_write  = 1'($urandom);
            #1;

            exp_ready = (!m_valid || out_ready) && !m_waiting && (m_recover == 0) && !flush;
            n_checks++; if (in_ready !== exp_ready) $display("FAIL rnd_in_ready@%0d got=%0h exp=%0h", cyc, in_ready, exp_ready); else n_pass++;
            n_checks++; if (out_valid !== m_valid) $display("FAIL rnd_out_valid@%0d got=%0h exp=%0h", cyc, out_valid, m_valid); else n_pass++;
            n_checks++; if ({out_alu_result, out_store_data, out_rd_addr, out_mem_read, out_mem_write, out_reg_write} !== m_out)
                $display("FAIL rnd_payload@%0d got=%0h/%0h/%0h/%0b%0b%0b exp=%0h/%0h/%0h/%0b%0b%0b", cyc,
                         out_alu_result, out_store_data, out_rd_addr, out_mem_read, out_mem_write, out_reg_write,
                         m_out.alu, m_out.sd, m_out.rd, m_out.mr, m_out.mw, m_out.rw); else n_pass++;
            n_checks++; if (status_q !== m_status) $display("FAIL rnd_status@%0d got=%0h exp=%0h", cyc, status_q, m_status); else n_pass++;
            n_checks++; if (sticky_status !== m_sticky) $display("FAIL rnd_sticky@%0d got=%0h exp=%0h", cyc, sticky_status, m_sticky); else n_pass++;
            n_checks++; if (trap_req !== m_waiting) $display("FAIL rnd_trap_req@%0d got=%0h exp=%0h", cyc, trap_req, m_waiting); else n_pass++;
            n_checks++; if (trap_cause !== m_cause) $display("FAIL rnd_cause@%0d got=%0b exp=%0b", cyc, trap_cause, m_cause); else n_pass++;

            acc  = in_valid && exp_ready;
            ovf  = alu_status[6] && trap_en && (alu_ctrl == 4'b0010 || alu_ctrl == 4'b0110 || alu_ctrl == 4'b1000);
            dz   = alu_status[2] && (alu_ctrl == 4'b1001);
            trap = acc && (ovf || dz);
`ifdef EX_MEM_STATUS_STICKY_EN
            m_sticky = (sticky_clr ? 8'h00 : m_sticky) | (acc ? {alu_status[7:2], 2'b00} : 8'h00);
`endif
            if (acc) begin
                m_out    = '{alu: alu_result, sd: store_data, rd: rd_addr,
                             mr: mem_read && !trap, mw: mem_write && !trap, rw: reg_write && !trap};
                m_status = alu_status;
            end
            if (flush)          m_valid = 0;
            else if (acc)       m_valid = 1;
            else if (out_ready) m_valid = 0;

            if (m_recover > 0) begin
                m_recover--;
                if (m_recover == 0) m_cause = 2'b00;
            end else if (m_waiting) begin
                if (trap_ack) begin
                    m_waiting = 0;
                    m_recover = 1;
                end
            end else if (trap) begin
                m_waiting = 1;
                m_cause   = {dz, ovf};
            end
            step();
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_overflow_trap();
        test_divzero_trap();
        test_flush();
        test_reset_mid_trap();
        test_sticky();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the datapath width.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, the register-address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1, in_ready  output  1  upstream (execute-stage) handshake.
REQ-006 alu_result  input  DATA_W, alu_status  input  8, alu_ctrl  input  4  ALU outputs and opcode.
REQ-007 store_data  input  DATA_W, rd_addr  input  REG_ADDR_W, mem_read/mem_write/reg_write  input  1 each  control bits.
REQ-008 trap_en  input  1  overflow trap enable; flush  input  1  kill the held entry.
REQ-009 out_valid  output  1, out_ready  input  1  downstream (memory-stage) handshake.
REQ-010 out_alu_result  output  DATA_W, out_store_data  output  DATA_W, out_rd_addr  output  REG_ADDR_W, out_mem_read/out_mem_write/out_reg_write  output  1 each  registered payload.
REQ-011 status_q  output  8  status of the last accepted entry.
REQ-012 trap_req  output  1, trap_cause  output  2, trap_ack  input  1  trap handshake to the control unit.
REQ-013 sticky_status  output  8, sticky_clr  input  1  accumulated flags (see Configuration).

Function
REQ-014 Status bit map: 7 zero, 6 overflow, 5 carry, 4 negative, 3 odd, 2 divide-by-zero, 1:0 reserved.
REQ-015 in_ready SHALL = (!out_valid || out_ready) && state==IDLE && !flush.
REQ-016 An accept (in_valid && in_ready) SHALL register the payload and set out_valid in the next cycle; latency is 1 cycle.
REQ-017 With out_valid high and out_ready low, all outputs SHALL hold stable.
REQ-018 Simultaneous output transfer and new accept SHALL replace the entry with no bubble.
REQ-019 Overflow trap SHALL fire on accept when alu_status[6] && trap_en && alu_ctrl is 4'b0010, 4'b0110 or 4'b1000.
REQ-020 Divide-by-zero trap SHALL fire on accept when alu_status[2] && alu_ctrl==4'b1001, regardless of trap_en.
REQ-021 trap_cause SHALL be 01 for overflow, 10 for divide-by-zero, and 11 for both.
REQ-022 On a trap the entry SHALL still be forwarded, but with out_reg_write, out_mem_write and out_mem_read forced to 0.
REQ-023 FSM states SHALL be IDLE, TRAP_PEND and TRAP_ACK; IDLE->TRAP_PEND on a trapping accept.
REQ-024 TRAP_PEND SHALL assert trap_req; on trap_ack it SHALL go to TRAP_ACK, which SHALL last 1 cycle (trap_req low) and then return to IDLE.
REQ-025 trap_cause SHALL hold from trap entry until the return to IDLE; it SHALL be 00 otherwise.
REQ-026 flush SHALL clear out_valid in the next cycle and block acceptance that cycle; it SHALL NOT alter FSM state or trap_req.
REQ-027 flush together with out_ready SHALL count as no transfer.
REQ-028 status_q SHALL update only on accept.

Reset
REQ-029 While rst_n is low, all of the following SHALL hold:
- out_valid=0, all payload outputs 0, status_q=0, sticky_status=0.
- trap_req=0, trap_cause=00, state=IDLE.
- in_ready=0 during reset, 1 in the first cycle after release.
REQ-030 Reset during TRAP_PEND SHALL drop trap_req immediately (asynchronously) without trap_ack.

Configuration
REQ-031 Macro EX_MEM_STATUS_STICKY_EN.
- Defined: sticky_status SHALL OR in alu_status[7:2] on every accept.
- sticky_clr SHALL zero it next cycle; a simultaneous accept's flags SHALL be kept.
- Undefined: sticky_status SHALL be constant 0 and sticky_clr SHALL be ignored.

Structure
REQ-032 Shared package mips_pkg SHALL hold:
- ALU opcode constants.
- Status bit indices.
- Trap cause encodings.
- The FSM state typedef.
REQ-033 The FSM SHALL be sub-module ex_mem_trap_fsm, instantiated once.

Verification
REQ-034 Back-to-back: 3 accepts, alu_result 5, 6, 7, out_ready=1 -> out_alu_result 5, 6, 7 on consecutive cycles, out_valid continuous.
REQ-035 Backpressure: out_ready=0 for 4 cycles holding 0x1234 -> in_ready=0 and outputs stable; out_ready=1 -> transfer, new entry accepted in the same cycle.
REQ-036 Overflow: alu_ctrl=0010, status=0x50, trap_en=1, reg_write=1 -> out_reg_write=0, trap_req=1, cause 01; trap_ack after 3 cycles -> trap_req low, in_ready=1 two cycles after ack.
REQ-037 Divide-by-zero: alu_ctrl=1001, status=0x04, trap_en=0 -> cause 10, trap taken; status=0x44, alu_ctrl=1001 -> cause 10 (overflow ignored for divide).
REQ-038 Flush plus reset:
- flush with out_valid=1 -> out_valid=0 next cycle.
- rst_n low mid-TRAP_PEND -> trap_req=0 immediately, state IDLE.
REQ-039 Sticky, macro defined: accepts with status 0x80 then 0x10 -> sticky_status=0x90; sticky_clr -> 0x00.
